// File: rtl/pixel_issue_scheduler.sv
// Frame sequencer: raster-order pixel issue with credit limit, in-order result FIFO, frame-buffer write port.
// Optional PIXEL_SCHED_STATS_EN adds frame_cycles_out / stall_cycles_out statistics.
module pixel_issue_scheduler #(
  parameter int H_PIXELS     = 1280,
  parameter int V_PIXELS     = 720,
  parameter int MAX_INFLIGHT = 16,
  parameter int ADDR_W       = 20
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              issue_valid_out,
  input  logic              issue_ready_in,
  output logic [10:0]       x_out,
  output logic [9:0]        y_out,
  input  logic              result_valid_in,
  input  logic [11:0]       rgb_in,
  output logic              wr_en_out,
  input  logic              wr_ready_in,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [11:0]       wr_data_out,
  output logic              overflow_err_out
`ifdef PIXEL_SCHED_STATS_EN
  ,
  output logic [31:0]       frame_cycles_out,
  output logic [31:0]       stall_cycles_out
`endif
);

  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_INFLIGHT);
  localparam logic [10:0]       X_LAST    = 11'(H_PIXELS - 1);
  localparam logic [9:0]        Y_LAST    = 10'(V_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_PIXELS * V_PIXELS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [11:0]      mem [MAX_INFLIGHT];
  logic             issue_xfer;
  logic             wr_xfer;
  logic             fifo_full;
  logic             bad_result;
  logic             push;
  logic             last_pixel;
  logic             start_accept;

  // Valid depends only on registered state, never on issue_ready_in.
  assign issue_valid_out = (state == ST_ISSUE) && (outstanding < MAX_CNT);
  assign issue_xfer      = issue_valid_out && issue_ready_in;
  assign wr_en_out       = (fifo_count != '0);
  assign wr_xfer         = wr_en_out && wr_ready_in;
  assign wr_data_out     = wr_en_out ? mem[rd_ptr] : '0;
  assign fifo_full       = (fifo_count == MAX_CNT);
  assign bad_result      = result_valid_in && ((outstanding == '0) || (fifo_full && !wr_xfer));
  assign push            = result_valid_in && !bad_result;
  assign last_pixel      = (x_out == X_LAST) && (y_out == Y_LAST);
  assign start_accept    = (state == ST_IDLE) && start_in;
  assign busy_out        = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign frame_done_out  = (state == ST_DONE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_in) state <= ST_ISSUE;
        ST_ISSUE: if (issue_xfer && last_pixel) state <= ST_DRAIN;
        ST_DRAIN: if (outstanding == '0) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_out <= '0;
      y_out <= '0;
    end else if (issue_xfer) begin
      if (x_out == X_LAST) begin
        x_out <= '0;
        y_out <= (y_out == Y_LAST) ? '0 : y_out + 1'b1;
      end else begin
        x_out <= x_out + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      outstanding <= '0;
    end else begin
      case ({issue_xfer, wr_xfer})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (wr_xfer) rd_ptr <= rd_ptr + 1'b1;
      case ({push, wr_xfer})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; the output mux hides stale entries while empty.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= rgb_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_addr_out      <= '0;
      overflow_err_out <= 1'b0;
    end else begin
      if (start_accept) begin
        wr_addr_out <= '0;
      end else if (wr_xfer) begin
        wr_addr_out <= (wr_addr_out == ADDR_LAST) ? '0 : wr_addr_out + 1'b1;
      end
      if (bad_result) overflow_err_out <= 1'b1;
    end
  end

`ifdef PIXEL_SCHED_STATS_EN
  logic [31:0] frame_run;
  logic [31:0] stall_run;

  // frame_run counts the start cycle as 1; the DONE cycle is added when latching.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_run        <= '0;
      stall_run        <= '0;
      frame_cycles_out <= '0;
      stall_cycles_out <= '0;
    end else begin
      if (start_accept) begin
        frame_run <= 32'd1;
        stall_run <= '0;
      end else if (busy_out) begin
        frame_run <= frame_run + 32'd1;
        if (issue_valid_out && !issue_ready_in) stall_run <= stall_run + 32'd1;
      end
      if (state == ST_DONE) begin
        frame_cycles_out <= frame_run + 32'd1;
        stall_cycles_out <= stall_run;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_issue_scheduler.sv
// Randomized self-checking bench for pixel_issue_scheduler on a 4x2 frame with a 5-cycle model pipeline.
module tb_pixel_issue_scheduler;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int M    = 4;
  localparam int AW   = 3;
  localparam int NPIX = H * V;
  localparam int LAT  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          frame_done;
  logic          issue_valid;
  logic          issue_ready;
  logic [10:0]   x;
  logic [9:0]    y;
  logic          result_valid;
  logic [11:0]   rgb;
  logic          wr_en;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          overflow_err;
`ifdef PIXEL_SCHED_STATS_EN
  logic [31:0]   frame_cycles;
  logic [31:0]   stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          cyc = 0;
  bit          active = 0;
  int          issued = 0;
  int          written = 0;
  int          outstanding = 0;
  bit          err_exp = 0;
  logic [11:0] colour [NPIX];
  logic [11:0] fifo_q [$];
  int          pipe_due [$];
  logic [11:0] pipe_rgb [$];
  int          done_count = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  int          last_wr_cyc = 0;
  int          stall_seen = 0;

  always #5 clk = ~clk;

  pixel_issue_scheduler #(
    .H_PIXELS    (H),
    .V_PIXELS    (V),
    .MAX_INFLIGHT(M),
    .ADDR_W      (AW)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start),
    .busy_out        (busy),
    .frame_done_out  (frame_done),
    .issue_valid_out (issue_valid),
    .issue_ready_in  (issue_ready),
    .x_out           (x),
    .y_out           (y),
    .result_valid_in (result_valid),
    .rgb_in          (rgb),
    .wr_en_out       (wr_en),
    .wr_ready_in     (wr_ready),
    .wr_addr_out     (wr_addr),
    .wr_data_out     (wr_data),
    .overflow_err_out(overflow_err)
`ifdef PIXEL_SCHED_STATS_EN
    ,
    .frame_cycles_out(frame_cycles),
    .stall_cycles_out(stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_issue_valid"}, issue_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_overflow"}, overflow_err, 0);
  endtask

  task automatic model_reset();
    active = 0; issued = 0; written = 0; outstanding = 0; err_exp = 0;
    fifo_q.delete(); pipe_due.delete(); pipe_rgb.delete();
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic tick(input bit go, input bit ir, input bit wrr, input bit inject);
    bit iss;
    bit wrx;
    bit exp_valid;
    exp_valid = active && (issued < NPIX) && (outstanding < M);
    check("issue_valid", issue_valid, exp_valid);
    if (issue_valid) begin
      check("x", x, issued % H);
      check("y", y, issued / H);
    end
    check("wr_en", wr_en, fifo_q.size() != 0);
    if (wr_en && fifo_q.size() != 0) begin
      check("wr_addr", wr_addr, written % NPIX);
      check("wr_data", wr_data, fifo_q[0]);
    end
    check("overflow_err", overflow_err, err_exp);
    if (active && written < NPIX) check("busy", busy, 1);
    if (frame_done) begin
      done_count++;
      done_cyc = cyc;
      check("busy_at_done", busy, 0);
      active = 0;
    end

    start       = go;
    issue_ready = ir;
    wr_ready    = wrr;
    if (inject) begin
      result_valid = 1'b1;
      rgb          = 12'($urandom);
    end else if (pipe_due.size() != 0 && pipe_due[0] == cyc) begin
      result_valid = 1'b1;
      rgb          = pipe_rgb.pop_front();
      void'(pipe_due.pop_front());
    end else begin
      result_valid = 1'b0;
      rgb          = 12'($urandom);
    end

    iss = issue_valid && ir;
    wrx = wr_en && wrr;
    if (issue_valid && !ir) stall_seen++;
    if (result_valid) begin
      if (outstanding == 0 || (fifo_q.size() == M && !wrx)) err_exp = 1;
      else fifo_q.push_back(rgb);
    end
    if (wrx) begin
      void'(fifo_q.pop_front());
      written++;
      if (written == NPIX) last_wr_cyc = cyc;
    end
    if (iss) begin
      pipe_due.push_back(cyc + LAT);
      pipe_rgb.push_back(colour[issued]);
      issued++;
    end
    outstanding = outstanding + int'(iss) - int'(wrx);
    if (go && !active) begin
      active = 1; start_cyc = cyc; issued = 0; written = 0; stall_seen = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: always ready; 1: 10-cycle issue stall at (2,0); 2: write port held until FIFO full;
  // 3: random handshakes; 4: like 2 plus an extra result pushed into the full FIFO.
  task automatic run_frame(input int mode);
    int  budget;
    int  stall_left;
    int  hold_wait;
    bit  hold;
    bit  ir;
    bit  wrr;
    bit  inj;
    foreach (colour[i]) colour[i] = 12'($urandom);
    done_count = 0;
    budget     = 0;
    stall_left = (mode == 1) ? 10 : 0;
    hold       = (mode == 2 || mode == 4);
    hold_wait  = 0;
    tick(1, 1, 1, 0);
    while (done_count == 0 && budget < 500) begin
      ir = 1; wrr = 1; inj = 0;
      case (mode)
        1: if (issue_valid && x == 2 && y == 0 && stall_left > 0) begin
             ir = 0;
             stall_left--;
           end
        2, 4: if (hold) begin
             wrr = 0;
             if (issued == M && !issue_valid) hold_wait++;
             if (mode == 4 && hold_wait == 8) inj = 1;
             if (hold_wait == 10) begin
               check("held_wr_en", wr_en, 1);
               check("held_x", x, 0);
               check("held_y", y, 1);
               hold = 0;
             end
           end
        3: begin
             ir  = ($urandom_range(0, 3) != 0);
             wrr = ($urandom_range(0, 2) != 0);
           end
        default: ;
      endcase
      tick(0, ir, wrr, inj);
      budget++;
    end
    check("frame_done_seen", done_count, 1);
    repeat (3) tick(0, 1, 1, 0);
    check("single_done_pulse", done_count, 1);
    check("done_after_last_write", done_cyc - last_wr_cyc, 2);
    check("busy_after_frame", busy, 0);
    check("pixels_written", written, NPIX);
`ifdef PIXEL_SCHED_STATS_EN
    check("frame_cycles", frame_cycles, done_cyc - start_cyc + 1);
    check("stall_cycles", stall_cycles, (mode == 1) ? 10 : stall_seen);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; issue_ready = 1'b0; wr_ready = 1'b0;
    result_valid = 1'b0; rgb = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(3);

    // Stray result while idle: flagged, dropped, sticky across a full frame.
    tick(0, 0, 1, 1);
    repeat (3) tick(0, 0, 1, 0);
    check("err_while_idle", overflow_err, 1);
    run_frame(0);

    // Reset after three issues aborts the frame.
    foreach (colour[i]) colour[i] = 12'($urandom);
    tick(1, 1, 1, 0);
    for (int k = 0; k < 20 && issued < 3; k++) tick(0, 1, 1, 0);
    check("issued_before_abort", x, 3);
    rst = 1'b1; start = 1'b0; result_valid = 1'b0; issue_ready = 1'b0; wr_ready = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc++;
    run_frame(0);
    run_frame(4);
    check("err_fifo_full", overflow_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
